// File: rtl/pwm_dac_player.sv
// Sample player: buffers 16-bit samples in a FIFO, pops one per sample tick
// and reproduces its top WIDTH bits as a glitch-free PWM duty cycle.
module pwm_dac_player #(
  parameter int WIDTH         = 8,
  parameter int CLOCK_FREQ    = 100_000_000,
  parameter int SAMPLING_FREQ = 2000,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [15:0]                   sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          pwm_out,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TICK_DIV = CLOCK_FREQ / SAMPLING_FREQ;
  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = AW + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0]  PWM_LAST  = '1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  if (TICK_DIV < (1 << WIDTH)) begin : g_bad_div
    $error("pwm_dac_player: sample period shorter than one PWM period");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pwm_dac_player: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  function automatic logic [WIDTH-1:0] sample_to_duty(input logic [15:0] s);
    return s[15 -: WIDTH];
  endfunction

  logic [15:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [TICK_W-1:0] tick_cnt;
  logic [WIDTH-1:0]  pwm_cnt;
  logic [WIDTH-1:0]  pending_duty;
  logic [WIDTH-1:0]  active_duty;
  logic              push;
  logic              pop;
  logic              tick;
  logic              empty;

  // Ready depends only on the registered count, so a pop frees space one cycle later.
  assign sample_ready = !reset && (count < DEPTH_C);
  assign push         = sample_valid && sample_ready;
  assign tick         = enable && (tick_cnt == TICK_LAST);
  assign empty        = (count == '0);
  assign pop          = tick && !empty;
  assign fifo_count   = count;

  // Stage 0: sample FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage 1: sample tick, pop into pending_duty
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun     <= 1'b0;
      pending_duty <= '0;
    end else begin
      underrun <= tick && empty;
      if (pop) begin
        pending_duty <= sample_to_duty(mem[rd_ptr]);
      end
    end
  end

  // Stage 2: duty latched only at the period wrap, then compared against pwm_cnt
  always_ff @(posedge clk) begin
    if (reset) begin
      active_duty <= '0;
    end else if (enable && (pwm_cnt == PWM_LAST)) begin
      active_duty <= pending_duty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < active_duty);
    end
  end

endmodule

// File: doc/pwm_dac_player.md
Name: pwm_dac_player

Overview:
Playback counterpart to the PWM ADC path. Accepts 16-bit samples (the ADC `adc_out` format) on a valid/ready handshake and buffers them in a small FIFO. At SAMPLING_FREQ it pops one sample and reproduces it as a PWM duty cycle on `pwm_out`, which drives the external RC filter. Used for loopback tests (ADC → player) and for waveform output.

Parameters:
WIDTH, 8, PWM resolution in bits; duty = top WIDTH bits of the sample.
CLOCK_FREQ, 100_000_000, clk frequency in Hz.
SAMPLING_FREQ, 2000, playback sample rate in Hz.
FIFO_DEPTH, 16, sample FIFO entries; must be a power of 2 and ≥ 2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  playback enable
sample_in  input  16  sample data; unsigned, full-scale 0xFFFF
sample_valid  input  1  sample_in is valid this cycle
sample_ready  output  1  FIFO can accept a sample this cycle
pwm_out  output  1  PWM output to the RC filter
underrun  output  1  one-cycle pulse: a sample tick found the FIFO empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values:
  - FIFO empty, fifo_count = 0.
  - Tick counter, PWM counter, active_duty and pending_duty = 0.
  - pwm_out = 0, underrun = 0.
  - sample_ready = 0 while reset is high.
- Derived constants:
  - TICK_DIV = CLOCK_FREQ / SAMPLING_FREQ (integer divide).
  - Elaboration error if TICK_DIV < 2**WIDTH.
- Push side:
  - sample_ready = !reset && (fifo_count < FIFO_DEPTH). Combinational from registered count only.
  - A push occurs when sample_valid && sample_ready. The sample is written at the clock edge.
  - Pushes are accepted regardless of `enable`, so the FIFO can be preloaded.
- Sample tick:
  - While enable = 1, the tick counter counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for one cycle when the counter equals TICK_DIV-1.
  - While enable = 0, the counter is held at 0 and no ticks occur.
- Pop on tick:
  - If fifo_count > 0: pop the head entry; pending_duty ← head[15:16-WIDTH].
  - If the FIFO is empty: pending_duty is held and underrun = 1 for exactly that cycle.
- Simultaneous push and pop: fifo_count is unchanged and both operations take effect.
  - Push into a full FIFO cannot occur, because ready was already 0 that cycle.
  - Pop of an entry written in the same cycle cannot occur. A push into an empty FIFO is visible to a pop no earlier than the next cycle.
- PWM generator:
  - While enable = 1, a free-running WIDTH-bit counter pwm_cnt runs 0..2**WIDTH-1 and wraps.
  - pwm_out = (pwm_cnt < active_duty), registered.
  - Duty 0 gives constant 0. Maximum duty gives high for 2**WIDTH-1 of every 2**WIDTH cycles.
- Glitch-free duty update: active_duty ← pending_duty only in the cycle where pwm_cnt wraps from 2**WIDTH-1 to 0. The PWM period in progress is never altered.
- Latency: from the tick that pops a sample, the new duty appears at the next PWM period start, i.e. within 2**WIDTH + 2 cycles.
- Disable (enable falls):
  - On the next edge, tick counter, pwm_cnt and pwm_out are cleared to 0.
  - active_duty and pending_duty are retained.
  - FIFO contents are retained.
- Re-enable: counting restarts from 0. The first tick is TICK_DIV cycles later.
- Reset mid-operation: all state returns to reset values on the edge where reset = 1. Any in-flight push that cycle is dropped.

Test Plan:
Bench parameters: WIDTH=4, CLOCK_FREQ=1_000_000, SAMPLING_FREQ=10_000 (TICK_DIV=100), FIFO_DEPTH=4.
1. Reset, enable=1, push 0x8000 → one pop at the first tick; then pwm_out is high exactly 8 of every 16 cycles starting at the next PWM wrap.
2. Push 0x0000 then 0xFFFF, enable=1 → pwm_out is constant 0 for the first sample period, then high 15 of every 16 cycles after the second tick.
3. enable=0, hold sample_valid=1 → 4 samples accepted; then sample_ready=0 and fifo_count=4. Raise enable → count decrements by 1 every 100 cycles.
4. Enable with the FIFO empty → underrun pulses for 1 cycle every 100 cycles, and pwm_out keeps the last duty (0 after reset).
5. Full FIFO with sample_valid held, at a tick → pop happens; sample_ready rises the next cycle and the push is accepted, returning fifo_count to 4. With a count of 2, push and pop in the same cycle leave fifo_count = 2.
6. Assert reset mid-PWM-period with duty 12 → the next cycle shows pwm_out=0, fifo_count=0, sample_ready=1 after reset releases, and no underrun.
